addsub_pipe: RTL and testbench

- Parametrised, two-stage pipelined adder/subtractor with valid/ready handshakes on input and output.
- Successor to the fixed 16-bit combinational add/sub unit. Adds:
  - generic width
  - carry/borrow-in chaining for multiword arithmetic
  - signed overflow, zero and negative flags
  - backpressure
- Sits between operand-issue logic and the result writeback/accumulator path.

---
 rtl/addsub_pipe.sv | 118 +++++++++++
 tb/tb_addsub_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
// Define ADDSUB_PIPE_SAT_EN to add a per-transaction signed-saturation input (sat).
module addsub_pipe #(
    parameter  int WIDTH = 16,
    localparam int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             subtract,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int HI_W = WIDTH - LO_W;

    logic             s2_adv, s1_adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [LO_W:0]    lo_add;
    logic [HI_W:0]    hi_add;
    logic [WIDTH-1:0] raw_sum, sum_d;
    logic             ovf_d;

    logic             s1_valid_q;
    logic [LO_W-1:0]  s1_lo_q;
    logic             s1_c_q;
    logic [HI_W-1:0]  s1_ahi_q, s1_bhi_q;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             s1_sat_q;
`endif
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q, neg_q;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Subtraction is A + ~B + ~borrow; once B is inverted the mode is no longer needed.
    assign b_eff  = subtract ? ~b : b;
    assign c_eff  = subtract ? ~cin : cin;
    assign lo_add = {1'b0, a[LO_W-1:0]} + {1'b0, b_eff[LO_W-1:0]} + {{LO_W{1'b0}}, c_eff};

    assign hi_add  = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q} + {{HI_W{1'b0}}, s1_c_q};
    assign raw_sum = {hi_add[HI_W-1:0], s1_lo_q};
    assign ovf_d   = (s1_ahi_q[HI_W-1] == s1_bhi_q[HI_W-1]) &&
                     (raw_sum[WIDTH-1] != s1_ahi_q[HI_W-1]);

    always_comb begin
        sum_d = raw_sum;
`ifdef ADDSUB_PIPE_SAT_EN
        // On overflow both operands share A's sign, so clamp toward that sign's limit.
        if (s1_sat_q && ovf_d)
            sum_d = s1_ahi_q[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_c_q      <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
            s1_sat_q    <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_lo_q  <= lo_add[LO_W-1:0];
                    s1_c_q   <= lo_add[LO_W];
                    s1_ahi_q <= a[WIDTH-1:LO_W];
                    s1_bhi_q <= b_eff[WIDTH-1:LO_W];
`ifdef ADDSUB_PIPE_SAT_EN
                    s1_sat_q <= sat;
`endif
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= hi_add[HI_W];
                    ovf_q  <= ovf_d;
                    zero_q <= (sum_d == '0);
                    neg_q  <= sum_d[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=16): directed cases, stall, reset and random traffic
// scored against an integer-arithmetic reference model.
module tb_addsub_pipe;
    localparam int W = 16;
`ifdef ADDSUB_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, subtract, sat;
    logic [W-1:0] a, b, sum;
    logic         out_valid, out_ready, cout, ovf, zero, neg;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout, ovf, zero, neg;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .subtract(subtract),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    function automatic res_t model(int unsigned ua, int unsigned ub, bit ci, bit sub, bit s);
        res_t        e;
        int          sa, sb, r;
        int unsigned u;
        sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
        sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
        if (!sub) begin
            u      = ua + ub + ci;
            r      = sa + sb + int'(ci);
            e.cout = (u >= 65536);
        end else begin
            u      = ua + 65536 - ub - ci;
            r      = sa - sb - int'(ci);
            e.cout = (ua >= ub + ci);
        end
        e.sum = 16'(u % 65536);
        e.ovf = (r > 32767) || (r < -32768);
        if (SAT && s && e.ovf) e.sum = (sa < 0) ? 16'h8000 : 16'h7FFF;
        e.zero = (e.sum == 16'h0000);
        e.neg  = e.sum[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, account for handshakes, finish 1ns after the rise.
    task automatic step(output bit acc);
        res_t e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q[0];
                chk("sum",  32'(sum),  32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf",  32'(ovf),  32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
                chk("neg",  32'(neg),  32'(e.neg));
                if (out_ready) void'(q.pop_front());
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, cin, subtract, SAT && sat));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit ci,
                        input bit sub, input bit s);
        bit acc;
        a = va; b = vb; cin = ci; subtract = sub; sat = s; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; subtract = 1'b0; sat = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", 32'({cout, ovf, zero, neg}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Latency: one transaction, result visible after the second rising edge.
        a = 16'h1234; b = 16'h0001; cin = 1'b0; subtract = 1'b0; in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        chk("lat_accept", 32'(acc), 32'd1);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        step(acc);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("lat_sum", 32'(sum), 32'h1235);
        idle(1);

        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        send(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Saturation cases, each also with sat=0 (wraps in either build).
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Stall: four back-to-back offers while downstream is blocked for 5 cycles.
        begin
            int n_acc = 0;
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                a = 16'(16'h1000 * (n_acc + 1)); b = 16'(n_acc + 3);
                cin = 1'b0; subtract = n_acc[0]; in_valid = (n_acc < 4);
                step(acc);
                if (acc) n_acc++;
            end
            chk("stall_accepts", 32'(n_acc), 32'd2);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
            for (int i = 0; i < 12 && n_acc < 4; i++) begin
                a = 16'(16'h1000 * (n_acc + 1)); b = 16'(n_acc + 3);
                subtract = n_acc[0]; in_valid = 1'b1;
                step(acc);
                if (acc) n_acc++;
            end
            in_valid = 1'b0;
            chk("stall_all_accepted", 32'(n_acc), 32'd4);
            idle(4);
        end

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 16'h0001, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_flags", 32'({cout, ovf, zero, neg}), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(4);
        send(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       a = 16'h7FFF;
                1:       a = 16'h8000;
                2:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 16'h0001;
                1:       b = 16'h8000;
                2:       b = 16'h0000;
                default: b = 16'($urandom);
            endcase
            cin = 1'($urandom); subtract = 1'($urandom); sat = 1'($urandom);
            step(acc);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) step(acc);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
